// File: rtl/subservient_loader.sv
// Firmware loader: packs a byte stream little-endian into 32-bit words, writes them to the
// SRAM debug port over Wishbone while the core is held, then releases the core after a settle delay.
module subservient_loader #(
    parameter int memsize       = 512,
    parameter int aw            = $clog2(memsize),
    parameter int settle_cycles = 10,
    parameter int ack_timeout   = 255
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_ni,
    input  logic          i_start,
    input  logic [aw:0]   i_len,
    input  logic [7:0]    i_byte,
    input  logic          i_byte_valid,
    output logic          o_byte_ready,
    output logic [31:0]   o_wb_adr,
    output logic [31:0]   o_wb_dat,
    output logic [3:0]    o_wb_sel,
    output logic          o_wb_we,
    output logic          o_wb_stb,
    input  logic          i_wb_ack,
    output logic          o_run,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic [2:0]    o_state
);

    localparam int sw = (settle_cycles > 1) ? $clog2(settle_cycles + 1) : 1;
    localparam int tw = (ack_timeout > 1) ? $clog2(ack_timeout + 1) : 1;
    localparam logic [aw:0]   max_len     = (aw + 1)'(memsize);
    localparam logic [sw-1:0] settle_last = sw'(settle_cycles - 1);
    localparam logic [tw-1:0] timeout_last = tw'(ack_timeout - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COLLECT = 3'd1,
        WRITE   = 3'd2,
        SETTLE  = 3'd3,
        RUN     = 3'd4
    } state_t;

    state_t          state;
    logic [aw:0]     len;
    logic [aw:0]     byte_cnt;
    logic [aw-2:0]   word_idx;
    logic [31:0]     word;
    logic [sw-1:0]   settle_cnt;
    logic [tw-1:0]   to_cnt;

    logic [aw:0]     byte_cnt_nxt;
    logic            last_byte;
    logic [31:0]     word_nxt;

    assign o_state      = state;
    assign byte_cnt_nxt = byte_cnt + 1'b1;
    assign last_byte    = (byte_cnt[1:0] == 2'd3) || (byte_cnt_nxt == len);

    always_comb begin
        word_nxt = word;
        word_nxt[8*byte_cnt[1:0] +: 8] = i_byte;
    end

    // Stream handshake: a byte transfers on every rising edge where i_byte_valid and
    // o_byte_ready are both high; the source holds i_byte stable while valid is high and ready is low.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state        <= IDLE;
            len          <= '0;
            byte_cnt     <= '0;
            word_idx     <= '0;
            word         <= '0;
            settle_cnt   <= '0;
            to_cnt       <= '0;
            o_byte_ready <= 1'b0;
            o_wb_adr     <= '0;
            o_wb_dat     <= '0;
            o_wb_sel     <= '0;
            o_wb_we      <= 1'b0;
            o_wb_stb     <= 1'b0;
            o_run        <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            case (state)
                IDLE, RUN: begin
                    if (i_start) begin
                        o_done     <= 1'b0;
                        o_err      <= 1'b0;
                        o_run      <= 1'b0;
                        len        <= i_len;
                        byte_cnt   <= '0;
                        word_idx   <= '0;
                        word       <= '0;
                        settle_cnt <= '0;
                        if (i_len > max_len) begin
                            o_err  <= 1'b1;
                            o_busy <= 1'b0;
                            state  <= IDLE;
                        end else if (i_len == '0) begin
                            o_busy <= 1'b1;
                            state  <= SETTLE;
                        end else begin
                            o_busy       <= 1'b1;
                            o_byte_ready <= 1'b1;
                            state        <= COLLECT;
                        end
                    end
                end

                COLLECT: begin
                    if (i_byte_valid && o_byte_ready) begin
                        word     <= word_nxt;
                        byte_cnt <= byte_cnt_nxt;
                        if (last_byte) begin
                            o_byte_ready <= 1'b0;
                            state        <= WRITE;
                        end
                    end
                end

                WRITE: begin
                    // First WRITE cycle presents the word; the bus is then frozen until ack or timeout.
                    if (!o_wb_stb) begin
                        o_wb_stb <= 1'b1;
                        o_wb_we  <= 1'b1;
                        o_wb_sel <= 4'b1111;
                        o_wb_adr <= {{(31 - aw){1'b0}}, word_idx, 2'b00};
                        o_wb_dat <= word;
                        to_cnt   <= '0;
                    end else if (i_wb_ack) begin
                        o_wb_stb <= 1'b0;
                        o_wb_we  <= 1'b0;
                        o_wb_sel <= '0;
                        word_idx <= word_idx + 1'b1;
                        word     <= '0;
                        if (byte_cnt == len) begin
                            settle_cnt <= '0;
                            state      <= SETTLE;
                        end else begin
                            o_byte_ready <= 1'b1;
                            state        <= COLLECT;
                        end
                    end else if (to_cnt == timeout_last) begin
                        o_wb_stb <= 1'b0;
                        o_wb_we  <= 1'b0;
                        o_wb_sel <= '0;
                        o_err    <= 1'b1;
                        o_busy   <= 1'b0;
                        o_run    <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                SETTLE: begin
                    if (settle_cnt == settle_last) begin
                        o_run  <= 1'b1;
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= RUN;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_subservient_loader.sv
// Randomized bench for subservient_loader: a byte driver feeds loads, a Wishbone responder/monitor
// compares every presented write against words computed from the byte list.
module tb_subservient_loader;

    localparam int memsize = 512;
    localparam int aw      = 9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [aw:0] i_len = '0;
    logic [7:0]  i_byte = '0;
    logic        i_byte_valid = 1'b0;
    logic        i_wb_ack = 1'b0;
    logic        o_byte_ready;
    logic [31:0] o_wb_adr;
    logic [31:0] o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic        o_wb_we;
    logic        o_wb_stb;
    logic        o_run;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic [2:0]  o_state;

    subservient_loader #(
        .memsize(memsize), .aw(aw), .settle_cycles(10), .ack_timeout(255)
    ) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .i_start(i_start), .i_len(i_len),
        .i_byte(i_byte), .i_byte_valid(i_byte_valid), .o_byte_ready(o_byte_ready),
        .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel), .o_wb_we(o_wb_we),
        .o_wb_stb(o_wb_stb), .i_wb_ack(i_wb_ack), .o_run(o_run), .o_busy(o_busy),
        .o_done(o_done), .o_err(o_err), .o_state(o_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [31:0] exp_adr_q[$];
    logic [31:0] exp_dat_q[$];
    logic [7:0]  load_bytes[$];
    int tests = 0;
    int fails = 0;
    bit ack_en = 1'b1;
    int ack_delay = 0;
    int wait_cnt = 0;
    int writes_seen = 0;
    int last_ack_cyc = 0;
    int run_rise_cyc = 0;
    int start_cyc = 0;
    int stb_len = 0;
    int last_stb_len = 0;
    logic prev_run = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- Wishbone responder + monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            i_wb_ack = 1'b0;
            if (o_run && !prev_run) run_rise_cyc = cyc;
            prev_run = o_run;
            if (o_wb_stb) begin
                stb_len++;
                check("ready_low_in_write", o_byte_ready, 1'b0);
                check("busy_in_write", o_busy, 1'b1);
                if (exp_adr_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got adr 0x%0h dat 0x%0h, required no write", o_wb_adr, o_wb_dat);
                end else begin
                    check("wb_adr", o_wb_adr, exp_adr_q[0]);
                    check("wb_dat", o_wb_dat, exp_dat_q[0]);
                    check("wb_sel", o_wb_sel, 4'hF);
                    check("wb_we", o_wb_we, 1'b1);
                end
                if (ack_en) begin
                    if (wait_cnt >= ack_delay) begin
                        i_wb_ack = 1'b1;
                        wait_cnt = 0;
                        if (exp_adr_q.size() != 0) begin
                            void'(exp_adr_q.pop_front());
                            void'(exp_dat_q.pop_front());
                        end
                        writes_seen++;
                        last_ack_cyc = cyc + 1;
                    end else begin
                        wait_cnt++;
                    end
                end
            end else begin
                if (stb_len != 0) last_stb_len = stb_len;
                stb_len = 0;
                wait_cnt = 0;
            end
        end
    end

    // ---------------- reference model ----------------
    task automatic model_push();
        int n;
        logic [31:0] w;
        n = load_bytes.size();
        for (int wi = 0; wi * 4 < n; wi++) begin
            w = 32'h0;
            for (int k = 0; k < 4; k++)
                if (wi * 4 + k < n) w = w | (32'(load_bytes[wi * 4 + k]) << (8 * k));
            exp_adr_q.push_back(32'(wi * 4));
            exp_dat_q.push_back(w);
        end
    endtask

    task automatic flush_model();
        exp_adr_q.delete();
        exp_dat_q.delete();
    endtask

    // ---------------- driver tasks (all entered just after a negedge) ----------------
    task automatic pulse_start(input int len);
        i_len = (aw + 1)'(len);
        i_start = 1'b1;
        start_cyc = cyc + 1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    // mode 0: valid always high, 1: valid every other cycle, 2: random valid
    task automatic feed(input int mode);
        int idx = 0;
        int t = 0;
        logic v;
        while (idx < load_bytes.size() && t < 3000) begin
            case (mode)
                0: v = 1'b1;
                1: v = ((t % 2) == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            i_byte_valid = v;
            i_byte = v ? load_bytes[idx] : 8'($urandom);
            if (v && o_byte_ready) idx++;
            @(negedge clk);
            t++;
        end
        i_byte_valid = 1'b0;
        if (idx != load_bytes.size()) check("feed_timeout", idx, load_bytes.size());
    endtask

    task automatic wait_run(input int budget);
        int t = 0;
        while (!o_run && !o_err && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (t >= budget) check("wait_run_timeout", t, budget - 1);
        @(negedge clk);
    endtask

    task automatic do_load(input int mode, input int delay);
        int n;
        int w0;
        n = load_bytes.size();
        ack_delay = delay;
        model_push();
        w0 = writes_seen;
        pulse_start(n);
        check("run_low_after_start", o_run, 1'b0);
        check("busy_after_start", o_busy, 1'b1);
        feed(mode);
        wait_run(n * 20 + 400);
        check("run", o_run, 1'b1);
        check("done", o_done, 1'b1);
        check("err", o_err, 1'b0);
        check("busy_idle", o_busy, 1'b0);
        check("write_count", writes_seen - w0, (n + 3) / 4);
        check("queue_empty", exp_adr_q.size(), 0);
        check("settle_delay", run_rise_cyc - ((n == 0) ? start_cyc : last_ack_cyc), 10);
    endtask

    task automatic random_bytes(input int n);
        load_bytes.delete();
        for (int i = 0; i < n; i++) load_bytes.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_run"}, o_run, 1'b0);
        check({tag, "_busy"}, o_busy, 1'b0);
        check({tag, "_done"}, o_done, 1'b0);
        check({tag, "_err"}, o_err, 1'b0);
        check({tag, "_stb"}, o_wb_stb, 1'b0);
        check({tag, "_we"}, o_wb_we, 1'b0);
        check({tag, "_sel"}, o_wb_sel, 4'h0);
        check({tag, "_ready"}, o_byte_ready, 1'b0);
        check({tag, "_adr"}, o_wb_adr, 32'h0);
        check({tag, "_dat"}, o_wb_dat, 32'h0);
        check({tag, "_state"}, o_state, 3'd0);
    endtask

    // ---------------- main stimulus ----------------
    initial begin
        int t;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        load_bytes.delete();
        for (int i = 0; i < 8; i++) load_bytes.push_back(8'(i));
        do_load(0, 0);

        load_bytes.delete();
        load_bytes.push_back(8'hAA); load_bytes.push_back(8'hBB); load_bytes.push_back(8'hCC);
        load_bytes.push_back(8'hDD); load_bytes.push_back(8'hEE);
        do_load(0, 0);

        random_bytes(13);
        do_load(1, 3);

        for (int r = 0; r < 6; r++) begin
            random_bytes($urandom_range(1, 40));
            do_load(2, $urandom_range(0, 3));
        end

        // oversize length
        pulse_start(513);
        check("oversize_err", o_err, 1'b1);
        check("oversize_run", o_run, 1'b0);
        check("oversize_busy", o_busy, 1'b0);
        check("oversize_done", o_done, 1'b0);
        repeat (6) @(negedge clk);
        check("oversize_no_stb", o_wb_stb, 1'b0);

        // zero length
        load_bytes.delete();
        do_load(0, 0);

        // ack never returned
        ack_en = 1'b0;
        random_bytes(4);
        model_push();
        pulse_start(4);
        feed(0);
        t = 0;
        while (!o_err && t < 600) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check("timeout_err", o_err, 1'b1);
        check("timeout_run", o_run, 1'b0);
        check("timeout_busy", o_busy, 1'b0);
        check("timeout_done", o_done, 1'b0);
        check("timeout_stb_len", last_stb_len, 255);
        check("timeout_stb_low", o_wb_stb, 1'b0);
        flush_model();
        ack_en = 1'b1;
        random_bytes(4);
        do_load(0, 0);

        // reload from RUN
        check("in_run", o_run, 1'b1);
        random_bytes(4);
        do_load(0, 1);

        // asynchronous reset in the middle of a write
        ack_en = 1'b0;
        random_bytes(4);
        model_push();
        pulse_start(4);
        feed(0);
        t = 0;
        while (!o_wb_stb && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("stb_before_reset", o_wb_stb, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_stb", o_wb_stb, 1'b0);
        check("async_rst_run", o_run, 1'b0);
        check("async_rst_busy", o_busy, 1'b0);
        flush_model();
        @(negedge clk);
        rst_n = 1'b1;
        ack_en = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_reset");
        random_bytes(7);
        do_load(2, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        fails++;
        $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/subservient_loader.md
Name: subservient_loader

Overview:
Hardware firmware loader for the Subservient SoC. Accepts a byte stream (from UART RX or SPI-flash reader), packs bytes little-endian into 32-bit words and issues Wishbone writes into the SRAM debug port while holding the core in debug mode. After the last word is written, it zero-pads any partial word, waits a settle interval, then releases the core.

Parameters:
memsize, 512, SRAM size in bytes
aw, $clog2(memsize), byte-address width
settle_cycles, 10, cycles between final write ack and core release (minimum 1)
ack_timeout, 255, maximum cycles to wait for wb ack before abort (minimum 1)

Ports:
wb_clk_i  in  1  clock
wb_rst_ni  in  1  asynchronous active-low reset
i_start  in  1  single-cycle pulse: begin load, honoured in IDLE and RUN only
i_len  in  aw+1  byte count, sampled on i_start
i_byte  in  8  stream data
i_byte_valid  in  1  stream valid
o_byte_ready  out  1  stream ready
o_wb_adr  out  32  byte address to SRAM debug port
o_wb_dat  out  32  write data
o_wb_sel  out  4  byte select
o_wb_we  out  1  write enable
o_wb_stb  out  1  strobe
i_wb_ack  in  1  acknowledge
o_run  out  1  drives la_data_in: 0 = debug mode/core held, 1 = core runs
o_busy  out  1  load in progress
o_done  out  1  sticky: last load completed
o_err  out  1  sticky: last load aborted

Behaviour:
- Reset (async assert, sync deassert): state IDLE. All outputs 0, so o_run=0 and the core is held.
- States: IDLE, COLLECT, WRITE, SETTLE, RUN. All outputs are registered.
- IDLE/RUN + i_start:
  - clear o_done, o_err; set o_run=0; latch i_len; clear byte and word counters.
  - i_len > memsize: set o_err, go to IDLE.
  - i_len == 0: go to SETTLE.
  - otherwise: go to COLLECT.
  - i_start in any other state is ignored.
- COLLECT: o_byte_ready=1, o_busy=1.
  - On valid&&ready, the byte goes into lane byte_cnt[1:0] (bits 8k+7:8k), and byte_cnt increments.
  - If the accepted byte fills lane 3 or makes byte_cnt==len, go to WRITE next cycle with o_byte_ready=0.
  - Unfilled upper lanes are zero.
- WRITE: o_wb_stb=1, o_wb_we=1, o_wb_sel=4'b1111, o_wb_adr = word_idx*4 (zero-extended), o_wb_dat = packed word.
  - Signals are held stable until i_wb_ack is sampled high.
  - stb/we drop the cycle after ack; word_idx increments.
  - Next state is SETTLE if byte_cnt==len, else COLLECT.
  - First stb rises one cycle after the accepting edge of the word's last byte.
- Ack timeout: a counter runs while stb=1. If it reaches ack_timeout with no ack: drop stb/we, set o_err, go to IDLE with o_run=0.
- SETTLE: count settle_cycles, then set o_run=1 and o_done=1, clear o_busy, go to RUN.
- RUN: o_run stays 1 until the next i_start.
- o_busy=1 in COLLECT, WRITE and SETTLE only.
- ack while stb=0 is ignored.
- Address never exceeds memsize-4, which the i_len check guarantees.

Test Plan:
- Load 8 bytes 00..07 (i_len=8), valid always high. Expect:
  - write 0x03020100 @0x0, then 0x07060504 @0x4;
  - sel=F each time;
  - o_run rises exactly 10 cycles after the second ack;
  - o_done=1, o_err=0.
- Load 5 bytes AA BB CC DD EE. Expect 0xDDCCBBAA @0x0, then 0x000000EE @0x4 (zero-padded); 2 writes total.
- Ack delayed 3 cycles on each write, with valid toggling every other cycle. Expect:
  - adr/dat/stb stable through each delay;
  - o_byte_ready=0 during WRITE;
  - no bytes lost (compare against the memory model).
- i_len=513 → o_err=1 in the cycle after start, no stb, o_run=0. i_len=0 → no writes, o_run=1 after 10 cycles.
- Ack never returned → stb drops after 255 cycles, o_err=1, o_run=0. A following i_start with 4 bytes completes normally.
- In RUN, pulse i_start with 4 bytes → o_run falls next cycle, reload occurs, o_run returns to 1. Assert wb_rst_ni low mid-WRITE → stb, o_run and o_busy go to 0 immediately (async).
